// File: rtl/complete_datapath_pkg.sv
// rtl/complete_datapath_pkg.sv - shared encodings, field positions and immediate helper for the datapath
package complete_datapath_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'b00,
        PC_ADDER = 2'b01,
        PC_RF    = 2'b10,
        PC_LABEL = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        IMM_Z5  = 2'b00,
        IMM_Z8  = 2'b01,
        IMM_S8  = 2'b10,
        IMM_S11 = 2'b11
    } imm_sel_t;

    typedef enum logic [1:0] {
        ALU_B_RD   = 2'b00,
        ALU_B_IMM  = 2'b01,
        ALU_B_ONE  = 2'b10,
        ALU_B_ZERO = 2'b11
    } alu_b_sel_t;

    typedef enum logic [1:0] {
        RF_WD_ALU = 2'b00,
        RF_WD_MDR = 2'b01,
        RF_WD_IMM = 2'b10,
        RF_WD_PC  = 2'b11
    } rf_wd_sel_t;

    // Instruction field bit positions within Mem_Data_Reg
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 8;
    localparam int RN_HI  = 7;
    localparam int RN_LO  = 5;
    localparam int RM_HI  = 4;
    localparam int RM_LO  = 2;
    localparam int OP_HI  = 1;
    localparam int OP_LO  = 0;
    localparam int LBL_HI = 10;

    function automatic logic [DATA_W-1:0] imm_extend(input logic [10:0] ir, input logic [1:0] sel);
        logic [DATA_W-1:0] r;
        case (imm_sel_t'(sel))
            IMM_Z5:  r = {11'b0, ir[4:0]};
            IMM_Z8:  r = {8'b0, ir[7:0]};
            IMM_S8:  r = {{8{ir[7]}}, ir[7:0]};
            default: r = {{5{ir[10]}}, ir[10:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dp_alu16.sv
// rtl/dp_alu16.sv - 16-bit ALU (ADD/SUB/AND/OR), ports: a, b, op in; result, zero, carry out
module dp_alu16
    import complete_datapath_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (alu_op_t'(op))
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_SUB: begin
                // carry out of A + ~B + 1 is the "no borrow" flag
                sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_AND: result = a & b;
            default: result = a | b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/complete_datapath.sv
// rtl/complete_datapath.sv - multi-cycle 16-bit RISC datapath: PC, memory, MDR, 8x16 RF, ALU, flags, Out_R
// Ports: clk/rst; controller selects and enables in; external load address/data in;
// Mem_Data_Reg, decoded fields, Imm_Out, Z_Reg, C_Reg, Out_R out.
// Macro DP_R0_ZERO_EN: R0 reads as zero and writes to it are dropped.
module complete_datapath
    import complete_datapath_pkg::*;
#(
    parameter int MEM_AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PC_Sel,
    input  logic        PC_Add_Src,
    input  logic        PC_ALU_Sel,
    input  logic        Mem_Addr_Sel,
    input  logic [15:0] Ext_Mem_Addr,
    input  logic        MemW_Data_Sel,
    input  logic [15:0] Ext_MemW_Data,
    input  logic        MemW_en,
    input  logic        Rd_Rm_Sel,
    input  logic        Rd_Reg_CE,
    input  logic        RF_Write_en,
    input  logic [1:0]  RF_Write_Data_Sel,
    input  logic [1:0]  Imm_Sel,
    input  logic        ALU_A_Sel,
    input  logic [1:0]  ALU_B_Sel,
    input  logic        ALU_Control,
    input  logic        ALUOut_Reg_CE,
    input  logic        Z_CE,
    input  logic        C_CE,
    input  logic        Out_R_CE,
    output logic [15:0] Mem_Data_Reg,
    output logic [4:0]  Opcode,
    output logic [2:0]  Rd_Addr,
    output logic [2:0]  Rn_Addr,
    output logic [2:0]  Rm_Addr,
    output logic [1:0]  ALU_Op,
    output logic [10:0] PC_Label11,
    output logic [15:0] Imm_Out,
    output logic        Z_Reg,
    output logic        C_Reg,
    output logic [15:0] Out_R
);

    localparam int MEM_DEPTH = 1 << MEM_AW;

    logic [DATA_W-1:0] pc, alu_out, rd_reg;
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [DATA_W-1:0] addr_full, mem_rdata, mem_wdata;
    logic [MEM_AW-1:0] mem_idx;
    logic              addr_unused;
    logic [2:0]        rf_p2_addr;
    logic [DATA_W-1:0] rf_p1, rf_p2, rf_wd;
    logic              rf_we;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res, pc_add, pc_next;
    logic [1:0]        alu_op;
    logic              alu_z, alu_c;

    // Instruction fields straight from the MDR
    assign Opcode     = Mem_Data_Reg[OPC_HI:OPC_LO];
    assign Rd_Addr    = Mem_Data_Reg[RD_HI:RD_LO];
    assign Rn_Addr    = Mem_Data_Reg[RN_HI:RN_LO];
    assign Rm_Addr    = Mem_Data_Reg[RM_HI:RM_LO];
    assign ALU_Op     = Mem_Data_Reg[OP_HI:OP_LO];
    assign PC_Label11 = Mem_Data_Reg[LBL_HI:0];
    assign Imm_Out    = imm_extend(Mem_Data_Reg[LBL_HI:0], Imm_Sel);

    // Memory: only the low MEM_AW address bits select a word
    assign addr_full   = Mem_Addr_Sel ? Ext_Mem_Addr : (PC_ALU_Sel ? alu_out : pc);
    assign mem_idx     = addr_full[MEM_AW-1:0];
    assign addr_unused = ^addr_full[DATA_W-1:MEM_AW];
    assign mem_rdata   = mem[mem_idx];
    assign mem_wdata   = MemW_Data_Sel ? Ext_MemW_Data : rd_reg;

    always_ff @(posedge clk) begin
        if (!rst && MemW_en) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // Register file read/write
    assign rf_p2_addr = Rd_Rm_Sel ? Rd_Addr : Rm_Addr;
`ifdef DP_R0_ZERO_EN
    assign rf_p1 = (Rn_Addr == 3'd0) ? '0 : rf[Rn_Addr];
    assign rf_p2 = (rf_p2_addr == 3'd0) ? '0 : rf[rf_p2_addr];
    assign rf_we = RF_Write_en && (Rd_Addr != 3'd0);
`else
    assign rf_p1 = rf[Rn_Addr];
    assign rf_p2 = rf[rf_p2_addr];
    assign rf_we = RF_Write_en;
`endif

    always_comb begin
        case (rf_wd_sel_t'(RF_Write_Data_Sel))
            RF_WD_ALU: rf_wd = alu_out;
            RF_WD_MDR: rf_wd = Mem_Data_Reg;
            RF_WD_IMM: rf_wd = Imm_Out;
            default:   rf_wd = pc;
        endcase
    end

    // ALU operand selection
    assign alu_a  = ALU_A_Sel ? pc : rf_p1;
    assign alu_op = ALU_Control ? ALU_ADD : ALU_Op;

    always_comb begin
        case (alu_b_sel_t'(ALU_B_Sel))
            ALU_B_RD:  alu_b = rd_reg;
            ALU_B_IMM: alu_b = Imm_Out;
            ALU_B_ONE: alu_b = 16'd1;
            default:   alu_b = '0;
        endcase
    end

    dp_alu16 u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .zero   (alu_z),
        .carry  (alu_c)
    );

    // PC next value
    assign pc_add = pc + (PC_Add_Src ? Imm_Out : 16'd1);

    always_comb begin
        case (pc_sel_t'(PC_Sel))
            PC_HOLD:  pc_next = pc;
            PC_ADDER: pc_next = pc_add;
            PC_RF:    pc_next = rf_p1;
            default:  pc_next = {5'b0, PC_Label11};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            Mem_Data_Reg <= '0;
            alu_out      <= '0;
            rd_reg       <= '0;
            Out_R        <= '0;
            Z_Reg        <= 1'b0;
            C_Reg        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else begin
            pc           <= pc_next;
            Mem_Data_Reg <= mem_rdata;
            if (rf_we)         rf[Rd_Addr] <= rf_wd;
            if (Rd_Reg_CE)     rd_reg      <= rf_p2;
            if (ALUOut_Reg_CE) alu_out     <= alu_res;
            if (Z_CE)          Z_Reg       <= alu_z;
            if (C_CE)          C_Reg       <= alu_c;
            if (Out_R_CE)      Out_R       <= rd_reg;
        end
    end

endmodule

// File: tb/tb_complete_datapath.sv
// tb/tb_complete_datapath.sv - directed and randomized check of complete_datapath against a behavioural model
module tb_complete_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PC_Sel;
    logic        PC_Add_Src, PC_ALU_Sel, Mem_Addr_Sel;
    logic [15:0] Ext_Mem_Addr;
    logic        MemW_Data_Sel;
    logic [15:0] Ext_MemW_Data;
    logic        MemW_en, Rd_Rm_Sel, Rd_Reg_CE, RF_Write_en;
    logic [1:0]  RF_Write_Data_Sel, Imm_Sel;
    logic        ALU_A_Sel;
    logic [1:0]  ALU_B_Sel;
    logic        ALU_Control, ALUOut_Reg_CE, Z_CE, C_CE, Out_R_CE;
    logic [15:0] Mem_Data_Reg;
    logic [4:0]  Opcode;
    logic [2:0]  Rd_Addr, Rn_Addr, Rm_Addr;
    logic [1:0]  ALU_Op;
    logic [10:0] PC_Label11;
    logic [15:0] Imm_Out;
    logic        Z_Reg, C_Reg;
    logic [15:0] Out_R;

    always #5 clk = ~clk;

    complete_datapath #(.MEM_AW(8)) dut (
        .clk(clk), .rst(rst), .PC_Sel(PC_Sel), .PC_Add_Src(PC_Add_Src),
        .PC_ALU_Sel(PC_ALU_Sel), .Mem_Addr_Sel(Mem_Addr_Sel), .Ext_Mem_Addr(Ext_Mem_Addr),
        .MemW_Data_Sel(MemW_Data_Sel), .Ext_MemW_Data(Ext_MemW_Data), .MemW_en(MemW_en),
        .Rd_Rm_Sel(Rd_Rm_Sel), .Rd_Reg_CE(Rd_Reg_CE), .RF_Write_en(RF_Write_en),
        .RF_Write_Data_Sel(RF_Write_Data_Sel), .Imm_Sel(Imm_Sel), .ALU_A_Sel(ALU_A_Sel),
        .ALU_B_Sel(ALU_B_Sel), .ALU_Control(ALU_Control), .ALUOut_Reg_CE(ALUOut_Reg_CE),
        .Z_CE(Z_CE), .C_CE(C_CE), .Out_R_CE(Out_R_CE), .Mem_Data_Reg(Mem_Data_Reg),
        .Opcode(Opcode), .Rd_Addr(Rd_Addr), .Rn_Addr(Rn_Addr), .Rm_Addr(Rm_Addr),
        .ALU_Op(ALU_Op), .PC_Label11(PC_Label11), .Imm_Out(Imm_Out), .Z_Reg(Z_Reg),
        .C_Reg(C_Reg), .Out_R(Out_R)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [15:0] m_pc, m_mdr, m_alu, m_rd, m_out;
    logic        m_z, m_c;
    logic [15:0] m_rf  [8];
    logic [15:0] m_mem [256];

    function automatic logic [15:0] m_imm(input logic [15:0] ir, input logic [1:0] sel);
        int v;
        case (sel)
            2'd0: v = int'(ir[4:0]);
            2'd1: v = int'(ir[7:0]);
            2'd2: begin v = int'(ir[7:0]);  if (v >= 128)  v -= 256;  end
            default: begin v = int'(ir[10:0]); if (v >= 1024) v -= 2048; end
        endcase
        return 16'(v);
    endfunction

    function automatic logic [15:0] m_reg(input logic [2:0] a);
`ifdef DP_R0_ZERO_EN
        if (a == 3'd0) return 16'd0;
`endif
        return m_rf[a];
    endfunction

    logic [15:0] mc_imm, mc_a, mc_b, mc_res, mc_wd, mc_npc;
    logic [7:0]  mc_addr;
    logic        mc_c;
    int          mc_s;

    always_comb begin
        mc_imm  = m_imm(m_mdr, Imm_Sel);
        mc_addr = Mem_Addr_Sel ? Ext_Mem_Addr[7:0] : (PC_ALU_Sel ? m_alu[7:0] : m_pc[7:0]);
        mc_a    = ALU_A_Sel ? m_pc : m_reg(m_mdr[7:5]);
        case (ALU_B_Sel)
            2'd0: mc_b = m_rd;
            2'd1: mc_b = mc_imm;
            2'd2: mc_b = 16'd1;
            default: mc_b = 16'd0;
        endcase
        mc_s = 0;
        mc_c = 1'b0;
        case (ALU_Control ? 2'd0 : m_mdr[1:0])
            2'd0: begin mc_s = int'(mc_a) + int'(mc_b); mc_res = 16'(mc_s); mc_c = (mc_s > 65535); end
            2'd1: begin mc_res = 16'(int'(mc_a) - int'(mc_b)); mc_c = (mc_a >= mc_b); end
            2'd2: mc_res = mc_a & mc_b;
            default: mc_res = mc_a | mc_b;
        endcase
        case (RF_Write_Data_Sel)
            2'd0: mc_wd = m_alu;
            2'd1: mc_wd = m_mdr;
            2'd2: mc_wd = mc_imm;
            default: mc_wd = m_pc;
        endcase
        case (PC_Sel)
            2'd0: mc_npc = m_pc;
            2'd1: mc_npc = 16'(int'(m_pc) + int'(PC_Add_Src ? mc_imm : 16'd1));
            2'd2: mc_npc = m_reg(m_mdr[7:5]);
            default: mc_npc = {5'd0, m_mdr[10:0]};
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 0; m_mdr <= 0; m_alu <= 0; m_rd <= 0; m_out <= 0; m_z <= 0; m_c <= 0;
            for (int i = 0; i < 8; i++) m_rf[i] <= 0;
        end else begin
            if (MemW_en) m_mem[mc_addr] <= MemW_Data_Sel ? Ext_MemW_Data : m_rd;
            m_mdr <= m_mem[mc_addr];
            m_pc  <= mc_npc;
`ifdef DP_R0_ZERO_EN
            if (RF_Write_en && m_mdr[10:8] != 3'd0) m_rf[m_mdr[10:8]] <= mc_wd;
`else
            if (RF_Write_en) m_rf[m_mdr[10:8]] <= mc_wd;
`endif
            if (Rd_Reg_CE)     m_rd  <= m_reg(Rd_Rm_Sel ? m_mdr[10:8] : m_mdr[4:2]);
            if (ALUOut_Reg_CE) m_alu <= mc_res;
            if (Z_CE)          m_z   <= (mc_res == 16'd0);
            if (C_CE)          m_c   <= mc_c;
            if (Out_R_CE)      m_out <= m_rd;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (checking) begin
            check("mdr", Mem_Data_Reg, m_mdr);
            check("fields", {Opcode, Rd_Addr, Rn_Addr, Rm_Addr, ALU_Op}, m_mdr);
            check("label", {5'd0, PC_Label11}, {5'd0, m_mdr[10:0]});
            check("imm", Imm_Out, m_imm(m_mdr, Imm_Sel));
            check("flags", {14'd0, Z_Reg, C_Reg}, {14'd0, m_z, m_c});
            check("out_r", Out_R, m_out);
        end
    end

    // Directed helpers
    logic [15:0] hold_addr = 16'h00F0;
    bit          use_ext   = 1'b1;

    task automatic idle();
        rst = 0; PC_Sel = 0; PC_Add_Src = 0; PC_ALU_Sel = 0;
        Mem_Addr_Sel = use_ext; Ext_Mem_Addr = hold_addr;
        MemW_Data_Sel = 0; Ext_MemW_Data = 0; MemW_en = 0;
        Rd_Rm_Sel = 0; Rd_Reg_CE = 0; RF_Write_en = 0; RF_Write_Data_Sel = 0;
        Imm_Sel = 0; ALU_A_Sel = 0; ALU_B_Sel = 0; ALU_Control = 0;
        ALUOut_Reg_CE = 0; Z_CE = 0; C_CE = 0; Out_R_CE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_write(input logic [15:0] addr, input logic [15:0] data);
        idle();
        Mem_Addr_Sel = 1; Ext_Mem_Addr = addr;
        MemW_Data_Sel = 1; Ext_MemW_Data = data; MemW_en = 1;
        tick();
    endtask

    task automatic set_instr(input logic [15:0] w);
        use_ext = 1; hold_addr = 16'h00F0;
        ext_write(16'h00F0, w);
        idle(); tick();
    endtask

    task automatic load_imm(input logic [2:0] r, input logic [7:0] v, input logic [1:0] sel);
        set_instr({5'd0, r, v});
        idle(); RF_Write_en = 1; RF_Write_Data_Sel = 2'd2; Imm_Sel = sel; tick();
    endtask

    task automatic alu_exec(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                            input logic [1:0] op);
        set_instr({5'd0, rd, rn, rm, op});
        idle(); Rd_Reg_CE = 1; tick();
        idle(); ALUOut_Reg_CE = 1; Z_CE = 1; C_CE = 1; tick();
    endtask

    task automatic alu_test(input string name, input logic [2:0] rn, input logic [2:0] rm,
                            input logic [2:0] rd, input logic [1:0] op,
                            input logic [15:0] exp, input logic ez, input logic ec);
        alu_exec(rn, rm, rd, op);
        check({name, "_flags"}, {14'd0, Z_Reg, C_Reg}, {14'd0, ez, ec});
        idle(); RF_Write_en = 1; tick();
        idle(); Rd_Rm_Sel = 1; Rd_Reg_CE = 1; tick();
        idle(); Out_R_CE = 1; tick();
        check({name, "_result"}, Out_R, exp);
    endtask

    logic [15:0] fill;

    initial begin
        idle();
        rst = 1; tick();
        check("reset_mdr", Mem_Data_Reg, 16'h0000);
        check("reset_flags", {14'd0, Z_Reg, C_Reg}, 16'h0000);
        check("reset_out", Out_R, 16'h0000);

        // Program load with junk in the ignored upper address bits
        for (int i = 0; i < 256; i++) begin
            case (i)
                0: fill = 16'hA000;   1: fill = 16'hA111;
                2: fill = 16'hA222;   3: fill = 16'hA333;
                5: fill = 16'h1234;   8: fill = 16'hA888;
                32: fill = 16'h1111;  254: fill = 16'hC5FE;
                default: fill = 16'($urandom);
            endcase
            ext_write({8'($urandom), 8'(i)}, fill);
        end
        hold_addr = 16'hAB05; idle(); tick();
        checking = 1'b1;
        check("load_mdr", Mem_Data_Reg, 16'h1234);
        check("load_opcode", {11'd0, Opcode}, 16'h0002);
        check("load_rd", {13'd0, Rd_Addr}, 16'h0002);

        // Fetch/increment
        idle(); rst = 1; tick();
        use_ext = 0;
        idle(); PC_Sel = 2'd1; tick(); check("fetch0", Mem_Data_Reg, 16'hA000);
        idle(); PC_Sel = 2'd1; tick(); check("fetch1", Mem_Data_Reg, 16'hA111);
        idle(); PC_Sel = 2'd1; tick(); check("fetch2", Mem_Data_Reg, 16'hA222);
        idle(); tick(); check("fetch_pc3", Mem_Data_Reg, 16'hA333);

        // ALU operations
        load_imm(3'd1, 8'hFF, 2'd2);
        load_imm(3'd2, 8'h01, 2'd2);
        load_imm(3'd4, 8'h05, 2'd2);
        load_imm(3'd5, 8'h03, 2'd2);
        set_instr(16'h0F0F);
        idle(); RF_Write_en = 1; RF_Write_Data_Sel = 2'd1; tick();
        alu_test("sub_5_3", 3'd4, 3'd5, 3'd6, 2'd1, 16'h0002, 1'b0, 1'b1);
        alu_test("add_wrap", 3'd1, 3'd2, 3'd3, 2'd0, 16'h0000, 1'b1, 1'b1);
        load_imm(3'd1, 8'hFF, 2'd1);
        alu_test("and", 3'd7, 3'd1, 3'd2, 2'd2, 16'h000F, 1'b0, 1'b0);
        alu_test("sub_3_5", 3'd5, 3'd4, 3'd6, 2'd1, 16'hFFFE, 1'b0, 1'b0);
        alu_test("or", 3'd7, 3'd1, 3'd3, 2'd3, 16'h0FFF, 1'b0, 1'b0);

        // Branches
        set_instr(16'h000A);
        idle(); PC_Sel = 2'd3; tick();
        set_instr(16'h07FE);
        idle(); Imm_Sel = 2'd3; PC_Add_Src = 1; PC_Sel = 2'd1; tick();
        use_ext = 0; idle(); tick();
        check("branch_rel", Mem_Data_Reg, 16'hA888);
        set_instr(16'h07FE);
        idle(); PC_Sel = 2'd3; tick();
        use_ext = 0; idle(); tick();
        check("branch_abs_mem", Mem_Data_Reg, 16'hC5FE);
        idle(); RF_Write_en = 1; RF_Write_Data_Sel = 2'd3; tick();
        idle(); Rd_Rm_Sel = 1; Rd_Reg_CE = 1; tick();
        idle(); Out_R_CE = 1; tick();
        check("branch_abs_pc", Out_R, 16'h07FE);

        // Store and load back
        set_instr(16'h0020);
        idle(); PC_Sel = 2'd3; tick();
        idle(); ALU_A_Sel = 1; ALU_B_Sel = 2'd3; ALU_Control = 1; ALUOut_Reg_CE = 1; tick();
        ext_write(16'h00F1, 16'hBEEF);
        hold_addr = 16'h00F1; idle(); tick();
        idle(); RF_Write_en = 1; RF_Write_Data_Sel = 2'd1; tick();
        idle(); Rd_Rm_Sel = 1; Rd_Reg_CE = 1; tick();
        use_ext = 0;
        idle(); PC_ALU_Sel = 1; MemW_en = 1; tick();
        check("store_old_data", Mem_Data_Reg, 16'h1111);
        idle(); PC_ALU_Sel = 1; tick();
        check("store_readback", Mem_Data_Reg, 16'hBEEF);
        idle(); PC_ALU_Sel = 1; RF_Write_en = 1; RF_Write_Data_Sel = 2'd1; tick();
        idle(); PC_ALU_Sel = 1; Rd_Rm_Sel = 1; Rd_Reg_CE = 1; tick();
        idle(); PC_ALU_Sel = 1; Out_R_CE = 1; tick();
        check("load_back", Out_R, 16'hBEEF);

        // Reset mid-sequence
        load_imm(3'd1, 8'hFF, 2'd2);
        load_imm(3'd2, 8'h01, 2'd2);
        alu_exec(3'd1, 3'd2, 3'd3, 2'd0);
        check("pre_reset_flags", {14'd0, Z_Reg, C_Reg}, 16'h0003);
        idle(); rst = 1; tick();
        check("mid_reset_flags", {14'd0, Z_Reg, C_Reg}, 16'h0000);
        check("mid_reset_out", Out_R, 16'h0000);
        use_ext = 0; idle(); tick();
        check("mid_reset_pc", Mem_Data_Reg, 16'hA000);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            rst               = ($urandom_range(0, 99) == 0);
            PC_Sel            = 2'($urandom);
            PC_Add_Src        = 1'($urandom);
            PC_ALU_Sel        = 1'($urandom);
            Mem_Addr_Sel      = 1'($urandom);
            Ext_Mem_Addr      = 16'($urandom);
            MemW_Data_Sel     = 1'($urandom);
            Ext_MemW_Data     = 16'($urandom);
            MemW_en           = 1'($urandom);
            Rd_Rm_Sel         = 1'($urandom);
            Rd_Reg_CE         = 1'($urandom);
            RF_Write_en       = 1'($urandom);
            RF_Write_Data_Sel = 2'($urandom);
            Imm_Sel           = 2'($urandom);
            ALU_A_Sel         = 1'($urandom);
            ALU_B_Sel         = 2'($urandom);
            ALU_Control       = 1'($urandom);
            ALUOut_Reg_CE     = 1'($urandom);
            Z_CE              = 1'($urandom);
            C_CE              = 1'($urandom);
            Out_R_CE          = 1'($urandom);
            tick();
        end

        idle(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
